// File: rtl/ahb_lite_initiator.sv
// AHB-Lite single-word initiator: valid/ready command stream in, one response per command out.
// Address and data phases are pipelined so zero-wait slaves sustain one transfer per cycle.
module ahb_lite_initiator (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_WDATA,
    output logic        RSP_VALID,
    output logic [31:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        BUSY
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } aph_t;

    aph_t aph;
    logic dph_valid;
    logic dph_write;

    logic err_mask;
    logic advance;
    logic dph_done;
    logic accept;

    // An ERROR response stalls the pipeline: the pending address phase is hidden
    // (HTRANS IDLE) for both error cycles and re-presented once the error completes.
    assign err_mask = dph_valid & HRESP;
    assign advance  = HREADY & ~err_mask;
    assign dph_done = dph_valid & HREADY;
    assign accept   = CMD_VALID & CMD_READY;

    assign CMD_READY = ~aph.valid | advance;
    assign BUSY      = aph.valid | dph_valid;

    assign HTRANS    = (aph.valid & ~err_mask) ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = aph.addr;
    assign HWRITE    = aph.write;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            aph <= '0;
        end else if (accept) begin
            aph <= '{valid: 1'b1, write: CMD_WRITE,
                     addr: CMD_ADDR & 32'hFFFF_FFFC, wdata: CMD_WDATA};
        end else if (advance) begin
            aph.valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dph_valid <= 1'b0;
            dph_write <= 1'b0;
            HWDATA    <= '0;
        end else if (advance) begin
            dph_valid <= aph.valid;
            dph_write <= aph.write;
            if (aph.valid && aph.write)
                HWDATA <= aph.wdata;
        end else if (dph_done) begin
            // error completion: data phase retires without the address stage moving
            dph_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            RSP_VALID <= 1'b0;
            RSP_RDATA <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            RSP_VALID <= dph_done;
            if (dph_done) begin
                RSP_ERR   <= HRESP;
                RSP_RDATA <= (!HRESP && !dph_write) ? HRDATA : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_initiator.sv
// Randomized bench for ahb_lite_initiator: a TB-side slave with random waits/errors
// plus a queue-based scoreboard of accepted commands and expected responses.
module tb_ahb_lite_initiator;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic        CMD_WRITE = 1'b0;
    logic [31:0] CMD_ADDR = '0;
    logic [31:0] CMD_WDATA = '0;
    logic        RSP_VALID;
    logic [31:0] RSP_RDATA;
    logic        RSP_ERR;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic        BUSY;

    ahb_lite_initiator dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .BUSY(BUSY)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct { logic write; logic [31:0] addr; logic [31:0] wdata; } cmd_t;
    typedef struct { logic err; logic [31:0] rdata; } rsp_t;

    cmd_t cmd_q[$];     // accepted, not yet taken by the slave as an address phase
    rsp_t exp_q[$];     // expected responses in command order

    // slave data-phase state
    bit   dp_active = 0;
    cmd_t dp_cmd;
    int   dp_wait = 0;
    bit   dp_err = 0;
    int   err_phase = 0;

    // pre-edge snapshot
    logic [1:0]  s_trans;
    logic        s_hready, s_hresp, s_cvalid, s_cready;
    logic [31:0] s_hrdata;
    cmd_t        s_cmd;
    bit          rsp_due = 0;

    localparam int NCYC = 3000;

    initial begin
        bit fast, stop_cmds, done_now, exp_ready, exp_busy;
        logic [1:0] exp_trans;
        cmd_t c;
        rsp_t r;

        // reset state
        repeat (2) @(posedge HCLK);
        #1;
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_valid", RSP_VALID, 1'b0);
        chk("rst_rsp_rdata", RSP_RDATA, 32'h0);
        chk("rst_rsp_err", RSP_ERR, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_cmd_ready", CMD_READY, 1'b1);
        HRESETn = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            fast      = (cyc < 200);
            stop_cmds = (cyc >= NCYC - 40);

            @(negedge HCLK);
            chk("rsp_valid", RSP_VALID, rsp_due);
            if (RSP_VALID && exp_q.size() > 0) begin
                r = exp_q.pop_front();
                chk("rsp_err", RSP_ERR, r.err);
                chk("rsp_rdata", RSP_RDATA, r.rdata);
            end
            exp_trans = (cmd_q.size() > 0) ? 2'b10 : 2'b00;
            if (dp_active && err_phase == 1) exp_trans = 2'b00;
            if (!(dp_active && err_phase == 2)) chk("htrans", HTRANS, exp_trans);
            exp_ready = (cmd_q.size() == 0) || (HREADY && !(dp_active && HRESP));
            chk("cmd_ready", CMD_READY, exp_ready);
            exp_busy = (cmd_q.size() > 0) || dp_active;
            chk("busy", BUSY, exp_busy);
            if (HTRANS == 2'b10 && cmd_q.size() > 0) begin
                chk("haddr", HADDR, cmd_q[0].addr & 32'hFFFF_FFFC);
                chk("hwrite", HWRITE, cmd_q[0].write);
            end
            if (dp_active && dp_cmd.write) chk("hwdata", HWDATA, dp_cmd.wdata);
            chk("hsize", HSIZE, 3'b010);
            chk("hburst", HBURST, 3'b000);
            chk("hprot", HPROT, 4'b0011);
            chk("hmastlock", HMASTLOCK, 1'b0);

            s_trans = HTRANS; s_hready = HREADY; s_hresp = HRESP; s_hrdata = HRDATA;
            s_cvalid = CMD_VALID; s_cready = CMD_READY;
            s_cmd = '{write: CMD_WRITE, addr: CMD_ADDR, wdata: CMD_WDATA};

            @(posedge HCLK);
            done_now = 0;
            if (dp_active && s_hready) begin
                r.err   = s_hresp;
                r.rdata = (s_hresp || dp_cmd.write) ? 32'h0 : s_hrdata;
                exp_q.push_back(r);
                dp_active = 0;
                done_now = 1;
            end
            if (s_trans == 2'b10 && s_hready && cmd_q.size() > 0) begin
                dp_cmd    = cmd_q.pop_front();
                dp_active = 1;
                dp_wait   = fast ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                dp_err    = !fast && ($urandom_range(0, 7) == 0);
                err_phase = 0;
            end
            if (s_cvalid && s_cready) cmd_q.push_back(s_cmd);
            rsp_due = done_now;

            #1;
            HRDATA = $urandom;
            if (dp_active && dp_err) begin
                if (err_phase == 0) begin HREADY = 1'b0; HRESP = 1'b1; err_phase = 1; end
                else begin HREADY = 1'b1; HRESP = 1'b1; err_phase = 2; end
            end else if (dp_active && dp_wait > 0) begin
                HREADY = 1'b0; HRESP = 1'b0; dp_wait--;
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
            end

            if (!(CMD_VALID && !(s_cvalid && s_cready))) begin
                CMD_VALID = !stop_cmds && (fast || $urandom_range(0, 9) < 7);
                CMD_WRITE = $urandom_range(0, 1);
                CMD_ADDR  = $urandom;
                CMD_WDATA = $urandom;
            end
        end

        chk("drain_left", exp_q.size() + cmd_q.size() + int'(dp_active), 0);

        // reset asserted while a read sits in a waited data phase
        CMD_VALID = 1'b1; CMD_WRITE = 1'b0; CMD_ADDR = 32'h0000_0107; HREADY = 1'b1; HRESP = 1'b0;
        @(posedge HCLK); #1;
        CMD_VALID = 1'b0;
        chk("mid_haddr", HADDR, 32'h0000_0104);
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        chk("mid_busy_pre", BUSY, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        chk("mid_htrans", HTRANS, 2'b00);
        chk("mid_busy", BUSY, 1'b0);
        chk("mid_cmd_ready", CMD_READY, 1'b1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1; HREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            chk("mid_no_rsp", RSP_VALID, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
